// File: rtl/paper_sig_gen.sv
// Paper-count square-wave generator: 32-bit DDS with a per-count tuning table or a
// manually loaded word. New words take effect only at phase wrap, so no runt pulses.
module paper_sig_gen #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 28
) (
  input  logic             clk_6M,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             mode,
  input  logic [3:0]       sel,
  input  logic [ACC_W-1:0] tw_in,
  input  logic             tw_load,
  output logic             square,
  output logic             tw_ack,
  output logic [ACC_W-1:0] tw_active,
  output logic [CNT_W-1:0] edge_cnt
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] tw_act_q, tw_act_d;
  logic [ACC_W-1:0] tw_manual_q;
  logic             square_q, square_d;
  logic             tw_ack_q, tw_ack_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

  logic [ACC_W-1:0] target;
  logic [ACC_W-1:0] acc_sum;
  logic             wrap;

  // Band-centre tuning words, TW = round(f * 2^32 / 6 MHz); unused counts park the output.
  function automatic logic [ACC_W-1:0] table_word(input logic [3:0] s);
    logic [31:0] w;
    case (s)
      4'd0:    w = 32'd28633115;
      4'd1:    w = 32'd50107952;
      4'd2:    w = 32'd68003649;
      4'd3:    w = 32'd82320207;
      4'd4:    w = 32'd96636764;
      4'd5:    w = 32'd108805838;
      4'd6:    w = 32'd125269879;
      4'd7:    w = 32'd136007298;
      4'd8:    w = 32'd146744716;
      4'd9:    w = 32'd157482134;
      4'd10:   w = 32'd166787897;
      default: w = 32'd0;
    endcase
    return ACC_W'(w);
  endfunction

  assign target          = mode ? tw_manual_q : table_word(sel);
  assign {wrap, acc_sum} = {1'b0, acc_q} + {1'b0, tw_act_q};

  always_ff @(posedge clk_6M or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_OFF;
      acc_q       <= '0;
      tw_act_q    <= '0;
      tw_manual_q <= '0;
      square_q    <= 1'b0;
      tw_ack_q    <= 1'b0;
      edge_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      tw_act_q   <= tw_act_d;
      square_q   <= square_d;
      tw_ack_q   <= tw_ack_d;
      edge_cnt_q <= edge_cnt_d;
      if (tw_load) begin
        tw_manual_q <= tw_in;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    tw_act_d   = tw_act_q;
    square_d   = square_q;
    tw_ack_d   = 1'b0;
    edge_cnt_d = edge_cnt_q;

    if (!enable || state_q == ST_OFF) begin
      // Stopped: hold phase at zero and keep the active word tracking the target.
      acc_d      = '0;
      square_d   = 1'b0;
      edge_cnt_d = '0;
      tw_act_d   = target;
      state_d    = enable ? ST_RUN : ST_OFF;
    end else begin
      acc_d    = acc_sum;
      square_d = acc_q[ACC_W-1];
      if (!square_q && acc_q[ACC_W-1]) begin
        edge_cnt_d = edge_cnt_q + CNT_W'(1);
      end

      case (state_q)
        ST_RUN: begin
          if (target != tw_act_q) begin
            // A parked (zero) word has no phase to protect, and a change landing on
            // a wrap is applied right there.
            if (tw_act_q == '0 || wrap) begin
              tw_act_d = target;
              tw_ack_d = 1'b1;
            end else begin
              state_d = ST_SWITCH;
            end
          end
        end
        ST_SWITCH: begin
          if (target == tw_act_q) begin
            state_d = ST_RUN;
          end else if (wrap) begin
            tw_act_d = target;
            tw_ack_d = 1'b1;
            state_d  = ST_RUN;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  assign square    = square_q;
  assign tw_ack    = tw_ack_q;
  assign tw_active = tw_act_q;
  assign edge_cnt  = edge_cnt_q;

endmodule

// File: tb/tb_paper_sig_gen.sv
// Self-checking bench for paper_sig_gen: directed scenarios plus random stimulus,
// every cycle compared against a word/phase reference model.
module tb_paper_sig_gen;

  logic        clk_6M = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] tw_in = 32'd0;
  logic        tw_load = 1'b0;
  logic        square;
  logic        tw_ack;
  logic [31:0] tw_active;
  logic [27:0] edge_cnt;

  int total = 0;
  int bad = 0;
  int ack_seen = 0;

  logic [31:0] tbl [0:15];

  // Reference model: phase value, applied word, registered outputs.
  logic [63:0] m_phase;
  logic [31:0] m_applied;
  logic [31:0] m_manual;
  logic        m_sq;
  logic        m_ack;
  logic        m_running;
  logic [27:0] m_cnt;

  paper_sig_gen #(.ACC_W(32), .CNT_W(28)) dut (
    .clk_6M    (clk_6M),
    .reset_n   (reset_n),
    .enable    (enable),
    .mode      (mode),
    .sel       (sel),
    .tw_in     (tw_in),
    .tw_load   (tw_load),
    .square    (square),
    .tw_ack    (tw_ack),
    .tw_active (tw_active),
    .edge_cnt  (edge_cnt)
  );

  always #5 clk_6M = ~clk_6M;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase   = 64'd0;
    m_applied = 32'd0;
    m_manual  = 32'd0;
    m_sq      = 1'b0;
    m_ack     = 1'b0;
    m_running = 1'b0;
    m_cnt     = 28'd0;
  endtask

  // Rules: stopped -> phase 0 and word follows target; running -> phase advances,
  // a differing target is taken at once if the word is zero, else at the next wrap.
  task automatic model_edge();
    logic [31:0] tgt;
    logic [63:0] sum;
    logic        nsq;
    tgt   = mode ? m_manual : tbl[sel];
    m_ack = 1'b0;
    if (!m_running || !enable) begin
      m_phase   = 64'd0;
      m_sq      = 1'b0;
      m_cnt     = 28'd0;
      m_applied = tgt;
    end else begin
      sum = m_phase + {32'd0, m_applied};
      nsq = m_phase[31];
      if (nsq && !m_sq) m_cnt = m_cnt + 28'd1;
      m_sq    = nsq;
      m_phase = {32'd0, sum[31:0]};
      if (tgt != m_applied && (m_applied == 32'd0 || sum[32])) begin
        m_applied = tgt;
        m_ack     = 1'b1;
      end
    end
    m_running = enable;
    if (tw_load) m_manual = tw_in;
  endtask

  task automatic step();
    @(posedge clk_6M);
    if (!reset_n) model_reset();
    else model_edge();
    #1;
    if (tw_ack) ack_seen++;
    check_val("square", {63'd0, square}, {63'd0, m_sq});
    check_val("tw_ack", {63'd0, tw_ack}, {63'd0, m_ack});
    check_val("tw_active", {32'd0, tw_active}, {32'd0, m_applied});
    check_val("edge_cnt", {36'd0, edge_cnt}, {36'd0, m_cnt});
  endtask

  task automatic wait_square_high(input string tag);
    int n;
    n = 0;
    while (square !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) check_val(tag, {63'd0, square}, 64'd1);
  endtask

  initial begin
    logic [63:0] first_rise;
    int          n, run_len, min_len, runs, ack_cycle;
    logic        prev, ack_ok;
    logic [27:0] cnt_hold;

    tbl[0]  = 32'd28633115;  tbl[1]  = 32'd50107952;  tbl[2]  = 32'd68003649;
    tbl[3]  = 32'd82320207;  tbl[4]  = 32'd96636764;  tbl[5]  = 32'd108805838;
    tbl[6]  = 32'd125269879; tbl[7]  = 32'd136007298; tbl[8]  = 32'd146744716;
    tbl[9]  = 32'd157482134; tbl[10] = 32'd166787897;
    for (int i = 11; i < 16; i++) tbl[i] = 32'd0;
    model_reset();

    // Reset values
    #2;
    check_val("rst_square", {63'd0, square}, 64'd0);
    check_val("rst_tw_ack", {63'd0, tw_ack}, 64'd0);
    check_val("rst_tw_active", {32'd0, tw_active}, 64'd0);
    check_val("rst_edge_cnt", {36'd0, edge_cnt}, 64'd0);
    repeat (3) step();

    // 1: table mode, 70 kHz, edge count over 60000 cycles
    reset_n = 1'b1; mode = 1'b0; sel = 4'd1; enable = 1'b1;
    ack_seen = 0;
    repeat (60000) step();
    check_val("t1_edges_700pm1", {63'd0, (edge_cnt >= 28'd699 && edge_cnt <= 28'd701)}, 64'd1);
    check_val("t1_tw_active", {32'd0, tw_active}, 64'd50107952);
    check_val("t1_no_ack", ack_seen, 0);
    $display("test 1: 70 kHz run edge_cnt=%0d", edge_cnt);

    // 2: manual word 0x8000_0000 loaded while running at zero word
    enable = 1'b0; mode = 1'b1;
    step();
    enable = 1'b1;
    repeat (5) step();
    check_val("t2_zero_word", {32'd0, tw_active}, 64'd0);
    tw_in = 32'h8000_0000; tw_load = 1'b1;
    step();
    tw_load = 1'b0;
    step();
    check_val("t2_ack", {63'd0, tw_ack}, 64'd1);
    check_val("t2_tw_active", {32'd0, tw_active}, 64'h8000_0000);
    repeat (4) step();
    for (int i = 0; i < 10; i++) begin
      prev = square;
      step();
      check_val("t2_toggle", {63'd0, square}, {63'd0, ~prev});
    end
    $display("test 2: 3 MHz manual toggle checked");

    // 3: sel 2 -> 10 during a high phase
    mode = 1'b0; sel = 4'd2;
    repeat (100) step();
    wait_square_high("t3_wait_high");
    repeat (5) step();
    sel = 4'd10;
    ack_seen = 0; min_len = 1000; run_len = 0; runs = 0; ack_cycle = -1; ack_ok = 1'b0;
    prev = square;
    for (int i = 0; i < 300; i++) begin
      step();
      if (tw_ack && ack_cycle < 0) begin
        ack_cycle = i;
        ack_ok = square;
      end
      if (ack_cycle == i - 1) ack_ok = ack_ok && !square;
      if (square == prev) run_len++;
      else begin
        if (runs > 0 && run_len + 1 < min_len) min_len = run_len + 1;
        runs++;
        run_len = 0;
      end
      prev = square;
    end
    check_val("t3_one_ack", ack_seen, 1);
    check_val("t3_ack_at_wrap", {63'd0, ack_ok}, 64'd1);
    check_val("t3_min_phase_ge12", {63'd0, (min_len >= 12)}, 64'd1);
    check_val("t3_tw_active", {32'd0, tw_active}, 64'd166787897);
    $display("test 3: switch ack at cycle %0d, shortest phase %0d", ack_cycle, min_len);

    // 4: park via unused count, then restart at 40 kHz
    sel = 4'd12;
    repeat (60) step();
    cnt_hold = edge_cnt;
    repeat (40) step();
    check_val("t4_parked_low", {63'd0, square}, 64'd0);
    check_val("t4_cnt_frozen", {36'd0, edge_cnt}, {36'd0, cnt_hold});
    check_val("t4_word_zero", {32'd0, tw_active}, 64'd0);
    sel = 4'd0;
    step();
    check_val("t4_restart_ack", {63'd0, tw_ack}, 64'd1);
    check_val("t4_restart_word", {32'd0, tw_active}, 64'd28633115);
    $display("test 4: parked then restarted at 40 kHz");

    // 5: enable dropped for 3 cycles, first-edge latency after re-enable
    repeat (200) step();
    enable = 1'b0;
    step();
    check_val("t5_square_off", {63'd0, square}, 64'd0);
    check_val("t5_cnt_off", {36'd0, edge_cnt}, 64'd0);
    step(); step();
    enable = 1'b1;
    step();
    first_rise = (64'h8000_0000 + 64'd28633115 - 64'd1) / 64'd28633115 + 64'd1;
    n = 0;
    while (square !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    check_val("t5_first_rise", n, first_rise);
    $display("test 5: first rise after %0d cycles", n);

    // 6: async reset while a switch is pending
    wait_square_high("t6_wait_high");
    sel = 4'd10;
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    check_val("t6_rst_square", {63'd0, square}, 64'd0);
    check_val("t6_rst_ack", {63'd0, tw_ack}, 64'd0);
    check_val("t6_rst_cnt", {36'd0, edge_cnt}, 64'd0);
    check_val("t6_rst_word", {32'd0, tw_active}, 64'd0);
    model_reset();
    repeat (3) step();
    reset_n = 1'b1;
    step();
    check_val("t6_off_tracks", {32'd0, tw_active}, 64'd166787897);
    check_val("t6_off_no_ack", {63'd0, tw_ack}, 64'd0);
    repeat (50) step();
    $display("test 6: async reset mid-switch");

    // 7: random stimulus
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) mode = ~mode;
      if ($urandom_range(0, 49) == 0) sel = 4'($urandom_range(0, 15));
      tw_load = ($urandom_range(0, 63) == 0);
      if (tw_load) tw_in = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 8));
      step();
    end
    tw_load = 1'b0;
    $display("test 7: random run done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/paper_sig_gen.md
Name: paper_sig_gen

Overview:
- Programmable square-wave stimulus generator: the transmit end of the paper-count frequency measurement path.
- Runs a 32-bit phase accumulator (DDS) at clk_6M and emits a square wave.
- Frequency comes from a paper-count table (centre of each count's band) or from a manually loaded tuning word.
- Output loops back to the frequency meter input for bench and board self-test.
- Frequency changes are applied only at phase wrap, so no runt pulses are produced.

Parameters:
ACC_W, 32, phase accumulator and tuning-word width
CNT_W, 28, width of rising-edge counter

Ports:
clk_6M  in  1  6 MHz system clock
reset_n  in  1  reset, asynchronous, active-low
enable  in  1  1 = run; 0 = stop, clear phase
mode  in  1  0 = table (sel), 1 = manual (tw_manual)
sel  in  4  paper count 0..10 for table mode
tw_in  in  ACC_W  manual tuning word
tw_load  in  1  1-cycle pulse; captures tw_in into tw_manual
square  out  1  generated square wave (registered)
tw_ack  out  1  1-cycle pulse when a new word becomes active while running
tw_active  out  ACC_W  currently applied tuning word
edge_cnt  out  CNT_W  rising edges of square since enable rose (wraps)

Behaviour:
- Reset: acc=0, tw_act=0, tw_manual=0, square=0, tw_ack=0, edge_cnt=0, state=OFF.
- Table (TW = round(f*2^32/6e6)), selected by sel:
  - 0: 40 kHz = 28633115
  - 1: 70 kHz = 50107952
  - 2: 95 kHz = 68003649
  - 3: 115 kHz = 82320207
  - 4: 135 kHz = 96636764
  - 5: 152 kHz = 108805838
  - 6: 175 kHz = 125269879
  - 7: 190 kHz = 136007298
  - 8: 205 kHz = 146744716
  - 9: 220 kHz = 157482134
  - 10: 233 kHz = 166787897
  - 11..15: 0 (output parked low)
- target = mode ? tw_manual : table[sel]. tw_manual updates on the cycle after a tw_load pulse.
- Accumulator: acc <= acc + tw_act, modulo 2^32. wrap = carry out of that add. square <= acc[31] (one-cycle register delay).
- edge_cnt increments on each cycle where square goes 0->1; wraps at 2^CNT_W.
- FSM:
  - OFF: enable=0. acc=0, square=0, edge_cnt=0, tw_act<=target every cycle, no tw_ack. enable=1 -> RUN.
  - RUN: accumulate. If target != tw_act: when tw_act==0 apply target next cycle (tw_act<=target, tw_ack=1, stay RUN); otherwise -> SWITCH.
  - SWITCH: accumulate with old tw_act. On the wrap cycle: tw_act<=target (value sampled that cycle), tw_ack=1, -> RUN. If target returns to tw_act before wrap -> RUN with no ack.
  - enable=0 in any state -> OFF next cycle.
- Wrap and target change in the same cycle: the change is applied at that wrap.
- tw_load during OFF: takes effect immediately via OFF tracking; no ack.
- Reset asserted mid-operation: all outputs return to reset values asynchronously.
- First rising edge after enable rises: cycle ceil(2^31/tw_act)+1, counted from the first RUN cycle.

Test Plan:
1. Reset, mode=0, sel=1, enable=1, run 6,000,000 cycles -> edge_cnt = 70,000 ±1; tw_active=50107952; no tw_ack.
2. mode=1, tw_in=0x8000_0000 with tw_load, enable=1 -> square toggles every cycle (3 MHz); tw_ack on the first running cycle after tw_act leaves 0.
3. Running at sel=2, switch sel to 10 mid-high-phase -> tw_ack exactly on the wrap cycle; no high or low phase shorter than the shorter of the old and new half-periods; tw_active=166787897 after the ack.
4. sel=12 while running -> square parks low after the next wrap; edge_cnt frozen; then sel=0 -> restarts with 40 kHz; ack on the first cycle after the change.
5. Drop enable for 3 cycles mid-run -> square=0 and edge_cnt=0 the next cycle; re-enable -> first rising edge at ceil(2^31/tw)+1 cycles.
6. Assert reset_n mid-SWITCH -> square, tw_ack, edge_cnt, tw_active all 0 immediately; after release, FSM in OFF.
